// File: rtl/pad_bus_target.sv
// Pad-side address/write/read handshake target with bursts, a read-only status window
// and a sticky error flag. Owns the R/W control registers driven into the core.
module pad_bus_target #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 48,
    parameter int RO_BASE  = 32,
    parameter int BURST_W  = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic                                AWRITEB,
    input  logic [ADDR_W-1:0]                   AADDR,
    input  logic [BURST_W-1:0]                  ABURST,
    input  logic                                AVALID,
    output logic                                AREADY,
    input  logic [DATA_W-1:0]                   WDATA,
    input  logic                                WVALID,
    output logic                                WREADY,
    output logic [DATA_W-1:0]                   RDATA,
    output logic                                RVALID,
    input  logic                                RREADY,
    output logic [RO_BASE*DATA_W-1:0]           REG_OUT,
    input  logic [(NUM_REGS-RO_BASE)*DATA_W-1:0] STAT_IN,
    output logic                                REG_WE,
    output logic [ADDR_W-1:0]                   REG_WADDR,
    output logic                                ERR,
    input  logic                                ERR_CLR
);

    // state   | meaning
    // S_IDLE  | waiting for an address handshake
    // S_WRITE | accepting write beats
    // S_READ  | returning read beats
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam int         NUM_RO  = NUM_REGS - RO_BASE;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W:0]   r_beats;
    logic [DATA_W-1:0]  r_regs [RO_BASE];
    logic [DATA_W-1:0]  r_rdata;
    logic               r_rvalid;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_err;

    logic               w_wr_beat;
    logic               w_rd_load;
    logic               w_rd_done;
    logic               w_is_rw;
    logic               w_in_range;
    logic               w_err_set;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [DATA_W-1:0]  w_rd_data;

    assign AREADY    = (r_state == S_IDLE);
    assign WREADY    = (r_state == S_WRITE);
    assign RDATA     = r_rdata;
    assign RVALID    = r_rvalid;
    assign REG_WE    = r_we;
    assign REG_WADDR = r_waddr;
    assign ERR       = r_err;

    genvar g;
    generate
        for (g = 0; g < RO_BASE; g++) begin : g_reg_out
            assign REG_OUT[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign w_is_rw    = ({1'b0, r_addr} < (ADDR_W+1)'(RO_BASE));
    assign w_in_range = ({1'b0, r_addr} < (ADDR_W+1)'(NUM_REGS));
    // Out-of-range start addresses fall through to plain mod-2**ADDR_W increment.
    assign w_addr_next = (r_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);

    assign w_wr_beat = (r_state == S_WRITE) && WVALID;
    assign w_rd_done = (r_state == S_READ) && r_rvalid && RREADY && (r_beats == '0);
    assign w_rd_load = (r_state == S_READ) &&
                       (!r_rvalid || (RREADY && (r_beats != '0)));
    assign w_err_set = (w_wr_beat && !w_is_rw) || (w_rd_load && !w_in_range);

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < RO_BASE; k++) begin
            if (r_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (r_addr == ADDR_W'(RO_BASE + j)) w_rd_data = STAT_IN[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_beats  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_err    <= 1'b0;
            for (int k = 0; k < RO_BASE; k++) r_regs[k] <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (AVALID) begin
                        r_addr  <= AADDR;
                        r_beats <= (BURST_W+1)'(ABURST) + (BURST_W+1)'(1);
                        r_state <= AWRITEB ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_wr_beat) begin
                        if (w_is_rw) begin
                            for (int k = 0; k < RO_BASE; k++) begin
                                if (r_addr == ADDR_W'(k)) r_regs[k] <= WDATA;
                            end
                            r_we    <= 1'b1;
                            r_waddr <= r_addr;
                        end
                        r_addr  <= w_addr_next;
                        r_beats <= r_beats - (BURST_W+1)'(1);
                        if (r_beats == (BURST_W+1)'(1)) r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    // r_beats counts beats not yet loaded into RDATA.
                    if (w_rd_done) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_rd_load) begin
                        r_rdata  <= w_rd_data;
                        r_rvalid <= 1'b1;
                        r_addr   <= w_addr_next;
                        r_beats  <= r_beats - (BURST_W+1)'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_err_set)    r_err <= 1'b1;
            else if (ERR_CLR) r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pad_bus_target.sv
// Scoreboard bench for pad_bus_target: directed transactions push expected read data and
// register-write addresses; a negedge monitor pops and compares as the DUT presents them.
module tb_pad_bus_target;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         AWRITEB;
    logic [5:0]   AADDR;
    logic [3:0]   ABURST;
    logic         AVALID;
    logic         AREADY;
    logic [7:0]   WDATA;
    logic         WVALID;
    logic         WREADY;
    logic [7:0]   RDATA;
    logic         RVALID;
    logic         RREADY;
    logic [255:0] REG_OUT;
    logic [127:0] STAT_IN;
    logic         REG_WE;
    logic [5:0]   REG_WADDR;
    logic         ERR;
    logic         ERR_CLR;

    pad_bus_target dut (
        .ACLK(ACLK), .ARESET(ARESET), .AWRITEB(AWRITEB), .AADDR(AADDR), .ABURST(ABURST),
        .AVALID(AVALID), .AREADY(AREADY), .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .REG_OUT(REG_OUT),
        .STAT_IN(STAT_IN), .REG_WE(REG_WE), .REG_WADDR(REG_WADDR), .ERR(ERR),
        .ERR_CLR(ERR_CLR)
    );

    always #5 ACLK = ~ACLK;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rd_seen = 0;
    int         rd_cyc[$];
    logic [7:0] exp_rd[$];
    logic [5:0] exp_we[$];
    logic [7:0] wq[$];

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, when handshake signals are stable for the next edge.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (RVALID && RREADY) begin
                    if (exp_rd.size() == 0) chk("rdata_unexpected", {24'd0, RDATA}, 32'hFFFF_FFFF);
                    else chk("rdata", {24'd0, RDATA}, {24'd0, exp_rd.pop_front()});
                    rd_seen++;
                    rd_cyc.push_back(cyc);
                end
                if (REG_WE) begin
                    if (exp_we.size() == 0) chk("reg_we_unexpected", {26'd0, REG_WADDR}, 32'hFFFF_FFFF);
                    else chk("reg_waddr", {26'd0, REG_WADDR}, {26'd0, exp_we.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_addr(input logic wr_b, input logic [5:0] a, input logic [3:0] b);
        logic got;
        int   t;
        AWRITEB = wr_b; AADDR = a; ABURST = b; AVALID = 1'b1;
        got = 1'b0;
        for (t = 0; t < 30 && !got; t++) begin
            got = AREADY;
            step();
        end
        if (!got) chk("addr_handshake_timeout", 32'd0, 32'd1);
        AVALID = 1'b0;
    endtask

    task automatic write_txn(input logic [5:0] a, input int n);
        logic got;
        do_addr(1'b0, a, 4'(n - 1));
        for (int i = 0; i < n; i++) begin
            WDATA = wq[i]; WVALID = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                got = WREADY;
                step();
            end
            if (!got) chk("wready_timeout", 32'd0, 32'd1);
        end
        WVALID = 1'b0;
        wq.delete();
    endtask

    task automatic rd_wait(input int n);
        int target;
        int t;
        target = rd_seen + n;
        for (t = 0; t < 40 && rd_seen < target; t++) step();
        if (rd_seen < target) chk("read_timeout", rd_seen, target);
    endtask

    task automatic clr_err();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; AWRITEB = 1'b0; AADDR = '0; ABURST = '0; AVALID = 1'b0;
        WDATA = '0; WVALID = 1'b0; RREADY = 1'b0; STAT_IN = '0; ERR_CLR = 1'b0;
        step(); step();
        ARESET = 1'b0;
        step();

        chk("rst_aready", AREADY, 1);
        chk("rst_wready", WREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_reg_we", REG_WE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_regs_zero", REG_OUT == '0, 1);

        // Single write
        wq.push_back(8'hA5); exp_we.push_back(6'd5);
        write_txn(6'd5, 1);
        chk("wready_after_last", WREADY, 0);
        step();
        chk("reg5", REG_OUT[5*8 +: 8], 8'hA5);
        chk("err_after_write", ERR, 0);
        chk("aready_after_write", AREADY, 1);

        // Burst write, then reg0 for the wrap read
        wq.push_back(8'h3C); wq.push_back(8'hC3);
        exp_we.push_back(6'd6); exp_we.push_back(6'd7);
        write_txn(6'd6, 2);
        wq.push_back(8'h33); exp_we.push_back(6'd0);
        write_txn(6'd0, 1);
        step();
        chk("reg6", REG_OUT[6*8 +: 8], 8'h3C);
        chk("reg7", REG_OUT[7*8 +: 8], 8'hC3);
        chk("reg0", REG_OUT[0 +: 8], 8'h33);

        // Burst read wrapping 47 -> 0
        STAT_IN[14*8 +: 8] = 8'h11;
        STAT_IN[15*8 +: 8] = 8'h22;
        RREADY = 1'b1;
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
        rd_cyc.delete();
        do_addr(1'b1, 6'd46, 4'd2);
        rd_wait(3);
        if (rd_cyc.size() >= 3) chk("burst_back_to_back", rd_cyc[2] - rd_cyc[0], 2);
        else chk("burst_beats", rd_cyc.size(), 3);
        step();
        chk("rvalid_after_burst", RVALID, 0);

        // Backpressure
        RREADY = 1'b0;
        exp_rd.push_back(8'hA5); exp_rd.push_back(8'h3C);
        do_addr(1'b1, 6'd5, 4'd1);
        begin
            int t;
            for (t = 0; t < 20 && !RVALID; t++) step();
            if (!RVALID) chk("bp_rvalid_timeout", 0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            chk("bp_rvalid_held", RVALID, 1);
            chk("bp_rdata_held", RDATA, 8'hA5);
            step();
        end
        RREADY = 1'b1;
        rd_wait(2);

        // Write to read-only address
        wq.push_back(8'hFF);
        write_txn(6'd40, 1);
        step();
        chk("ro_write_err", ERR, 1);
        chk("ro_write_regs", REG_OUT[5*8 +: 8], 8'hA5);
        clr_err();
        chk("err_cleared", ERR, 0);

        // Out-of-range read
        exp_rd.push_back(8'h00);
        do_addr(1'b1, 6'd60, 4'd0);
        rd_wait(1);
        chk("oor_read_err", ERR, 1);
        clr_err();
        chk("err_cleared2", ERR, 0);

        // Status window
        STAT_IN[3*8 +: 8] = 8'h5C;
        exp_rd.push_back(8'h5C);
        do_addr(1'b1, 6'd35, 4'd0);
        rd_wait(1);
        chk("status_no_err", ERR, 0);

        // Reset during beat 2 of a 4-beat write
        do_addr(1'b0, 6'd10, 4'd3);
        WDATA = 8'h01; WVALID = 1'b1;
        step();
        WDATA = 8'h02;
        ARESET = 1'b1;
        step(); step();
        WVALID = 1'b0;
        ARESET = 1'b0;
        step();
        chk("midrst_regs_zero", REG_OUT == '0, 1);
        chk("midrst_aready", AREADY, 1);
        chk("midrst_wready", WREADY, 0);
        chk("midrst_err", ERR, 0);
        wq.push_back(8'h77); exp_we.push_back(6'd10);
        write_txn(6'd10, 1);
        step();
        chk("fresh_reg10", REG_OUT[10*8 +: 8], 8'h77);
        chk("fresh_only_reg10", REG_OUT == (256'h77 << 80), 1);

        step(); step();
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("we_queue_drained", exp_we.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
